// File: rtl/seg7_scan_4d_pkg.sv
// Shared encodings for the keypad entry labs: FSM states, key codes and
// active-low seven-segment patterns ordered {a,b,c,d,e,f,g,dp}.
package seg7_scan_4d_pkg;

   typedef enum logic [2:0] {
      STAT_IDLE   = 3'd0,
      STAT_DIGIT3 = 3'd1,
      STAT_DIGIT2 = 3'd2,
      STAT_DIGIT1 = 3'd3,
      STAT_DIGIT0 = 3'd4,
      STAT_RESULT = 3'd5
   } stat_e;

   localparam logic [3:0] KEY_ADD      = 4'hA;
   localparam logic [3:0] KEY_SUBTRACT = 4'hB;
   localparam logic [3:0] KEY_MULTIPLY = 4'hC;
   localparam logic [3:0] KEY_ENTER    = 4'hD;

   localparam logic [7:0] SSD_0     = 8'b0000_0011;
   localparam logic [7:0] SSD_1     = 8'b1001_1111;
   localparam logic [7:0] SSD_2     = 8'b0010_0101;
   localparam logic [7:0] SSD_3     = 8'b0000_1101;
   localparam logic [7:0] SSD_4     = 8'b1001_1001;
   localparam logic [7:0] SSD_5     = 8'b0100_1001;
   localparam logic [7:0] SSD_6     = 8'b0100_0001;
   localparam logic [7:0] SSD_7     = 8'b0001_1111;
   localparam logic [7:0] SSD_8     = 8'b0000_0001;
   localparam logic [7:0] SSD_9     = 8'b0000_1001;
   localparam logic [7:0] SSD_ADD   = 8'b1001_1101;
   localparam logic [7:0] SSD_SUB   = 8'b1110_1101;
   localparam logic [7:0] SSD_MUL   = 8'b1101_0101;
   localparam logic [7:0] SSD_ENT   = 8'b0110_0001;
   localparam logic [7:0] SSD_DASH  = 8'b1111_1101;
   localparam logic [7:0] SSD_BLANK = 8'b1111_1111;

   // The entry FSM state in which digit position idx is being edited.
   function automatic stat_e digit_stat(input logic [1:0] idx);
      stat_e s;
      case (idx)
         2'd0:    s = STAT_DIGIT0;
         2'd1:    s = STAT_DIGIT1;
         2'd2:    s = STAT_DIGIT2;
         default: s = STAT_DIGIT3;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_scan_4d_ssd_decoder.sv
// Combinational 4-bit code to active-low seven-segment pattern decoder,
// shared with other labs.
module ssd_decoder
   import seg7_scan_4d_pkg::*;
(
   input  logic [3:0] code,
   output logic [7:0] pattern
);

   always_comb begin
      case (code)
         4'd0:         pattern = SSD_0;
         4'd1:         pattern = SSD_1;
         4'd2:         pattern = SSD_2;
         4'd3:         pattern = SSD_3;
         4'd4:         pattern = SSD_4;
         4'd5:         pattern = SSD_5;
         4'd6:         pattern = SSD_6;
         4'd7:         pattern = SSD_7;
         4'd8:         pattern = SSD_8;
         4'd9:         pattern = SSD_9;
         KEY_ADD:      pattern = SSD_ADD;
         KEY_SUBTRACT: pattern = SSD_SUB;
         KEY_MULTIPLY: pattern = SSD_MUL;
         KEY_ENTER:    pattern = SSD_ENT;
         default:      pattern = SSD_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_4d.sv
// Four-digit common-anode display scanner with edit-digit blink and optional
// leading-zero blanking; all outputs registered.
module seg7_scan_4d
   import seg7_scan_4d_pkg::*;
#(
   parameter int unsigned DIV_BITS   = 17,
   parameter int unsigned BLINK_BITS = 25,
   parameter bit          LZB        = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit3,
   input  logic [3:0] digit2,
   input  logic [3:0] digit1,
   input  logic [3:0] digit0,
   input  logic [2:0] state_ctrl,
   output logic [3:0] ssd_ctl,
   output logic [7:0] ssd_out
);

   logic [DIV_BITS-1:0]   div_cnt_q,   div_cnt_d;
   logic [1:0]            scan_idx_q,  scan_idx_d;
   logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
   logic [3:0]            ssd_ctl_q,   ssd_ctl_d;
   logic [7:0]            ssd_out_q,   ssd_out_d;

   logic [3:0] code;
   logic [7:0] glyph;
   logic       blink_off;
   logic       lz_blank;

   ssd_decoder u_decoder (
      .code    (code),
      .pattern (glyph)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      code     = digit0;
      lz_blank = 1'b0;
      case (scan_idx_q)
         2'd0: begin
            code     = digit0;
            lz_blank = 1'b0;
         end
         2'd1: begin
            code     = digit1;
            lz_blank = (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0);
         end
         2'd2: begin
            code     = digit2;
            lz_blank = (digit3 == 4'd0) && (digit2 == 4'd0);
         end
         default: begin
            code     = digit3;
            lz_blank = (digit3 == 4'd0);
         end
      endcase
   end

   assign blink_off = blink_cnt_q[BLINK_BITS-1] && (state_ctrl == digit_stat(scan_idx_q));

   always_comb begin
      div_cnt_d   = div_cnt_q + 1'b1;
      blink_cnt_d = blink_cnt_q + 1'b1;
      // Advance one slot on the cycle after the divider hits all-ones.
      scan_idx_d  = (&div_cnt_q) ? scan_idx_q + 2'd1 : scan_idx_q;
      ssd_ctl_d   = ~(4'b0001 << scan_idx_q);
      if (blink_off) begin
         ssd_out_d = SSD_BLANK;
      end else if (LZB && lz_blank) begin
         ssd_out_d = SSD_BLANK;
      end else begin
         ssd_out_d = glyph;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q   <= '0;
         scan_idx_q  <= '0;
         blink_cnt_q <= '0;
         ssd_ctl_q   <= 4'b1111;
         ssd_out_q   <= SSD_BLANK;
      end else begin
         div_cnt_q   <= div_cnt_d;
         scan_idx_q  <= scan_idx_d;
         blink_cnt_q <= blink_cnt_d;
         ssd_ctl_q   <= ssd_ctl_d;
         ssd_out_q   <= ssd_out_d;
      end
   end

   assign ssd_ctl = ssd_ctl_q;
   assign ssd_out = ssd_out_q;

endmodule

// File: doc/seg7_scan_4d.md
# seg7_scan_4d

Display-side reader for the four-digit keypad entry registers. It takes `digit3`..`digit0` and `state_ctrl` and time-multiplexes them onto the board's common-anode 4-digit seven-segment display. The digit currently being edited blinks, and operator key codes are shown as glyphs. It sits between the digit register block and the FPGA display pins.

## Interface
- `DIV_BITS`, default 17: width of the scan divider. Each digit is lit for 2^DIV_BITS clocks.
- `BLINK_BITS`, default 25: width of the blink counter. Its MSB is the blink phase.
- `LZB`, default 0: when 1, leading zeros are blanked.
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous reset, active-high.
- `digit3`..`digit0`  in  4 each: held values from the entry registers.
- `state_ctrl`  in  3: entry FSM state, with `STAT_*` encodings.
- `ssd_ctl`  out  4: digit enables, active-low. Bit n drives digit n.
- `ssd_out`  out  8: segments {a,b,c,d,e,f,g,dp}, active-low. The dp segment is always off (1).

## Operation
- `div_cnt` (DIV_BITS bits) is a free-running counter that increments every clock and wraps to 0.
- `scan_idx` (2 bits) increments in the cycle after `div_cnt` reaches all-ones. Scan order is 0→1→2→3→0.
- `blink_cnt` (BLINK_BITS bits) is free-running. The blink is in its off phase when the MSB is 1.
- Selected code: `code` = `digit[scan_idx]`.
- Decoding of `code`:
  - 0–9: standard digit patterns.
  - `KEY_ADD`, `KEY_SUBTRACT`, `KEY_MULTIPLY`, `KEY_ENTER`: `SSD_ADD`, `SSD_SUB`, `SSD_MUL`, `SSD_ENT` respectively.
  - Any other code: `SSD_DASH` (segment g only, i.e. 8'b1111_1101).
- Blink: if `state_ctrl` == `STAT_DIGITn`, `scan_idx` == n, and the blink is in the off phase, then `ssd_out` = 8'hFF (blank). `ssd_ctl` still selects the digit.
- Leading-zero blanking, active only when LZB=1:
  - blank3 = (digit3==0)
  - blank2 = blank3 & (digit2==0)
  - blank1 = blank2 & (digit1==0)
  - digit0 is never blanked.
  - A blanked digit drives `ssd_out` = 8'hFF.
- Priority, highest first: reset, then blink-off, then LZB blank, then decoded glyph.
- Other `state_ctrl` values, including idle and result states, cause no blinking.

## Timing
- Reset values: `ssd_ctl` = 4'b1111 and `ssd_out` = 8'hFF. `div_cnt`, `scan_idx` and `blink_cnt` are all 0.
- Outputs are registered. They reflect `scan_idx`, the digits and `state_ctrl` sampled on the previous clock, giving one cycle of latency.
- First visible frame: digit 0 is enabled (`ssd_ctl` = 4'b1110) from the first edge after `rst` deasserts.
- Each digit is enabled for exactly 2^DIV_BITS consecutive cycles. One full frame is 4·2^DIV_BITS cycles.
- Exactly one `ssd_ctl` bit is low at any time outside reset. There is no overlap cycle: enable and segments switch on the same edge.
- A digit input change mid-slot appears on `ssd_out` one clock later. Nothing waits for a slot boundary.
- A `valid` edge on the entry registers is asynchronous to this block. Digits are treated as quasi-static, and a single-frame glitch is acceptable.
- `rst` asserted mid-frame: on the next edge all outputs go to reset values and all counters clear. Scanning restarts at digit 0.
- Counter wrap-around is silent. There are no sticky or overflow flags.

## Structure
- Shared header `global.vh` holds:
  - the `STAT_DIGIT3..0` and `KEY_*` encodings, which already exist there;
  - the new `SSD_0`..`SSD_9`, `SSD_ADD`, `SSD_SUB`, `SSD_MUL`, `SSD_ENT`, `SSD_DASH` and `SSD_BLANK` 8-bit patterns.
- One combinational sub-module, `ssd_decoder` (4-bit code in, 8-bit pattern out), is reused by other labs.
- The top level holds the counters, digit mux, blink/LZB logic and output registers.

## Test plan
All scenarios use DIV_BITS=2 and BLINK_BITS=4.
- Reset: hold `rst` for 3 cycles with the digits at 1,2,3,4. Outputs stay at 4'b1111 and 8'hFF. After release, `ssd_ctl` = 1110 for 4 cycles with `ssd_out` = `SSD_4`, then 1101 with `SSD_3`, 1011 with `SSD_2`, 0111 with `SSD_1`, then back to 1110.
- Glyphs: digits {`KEY_ADD`, `KEY_MULTIPLY`, 4'hF, 9} give `SSD_ADD` on digit3, `SSD_MUL` on digit2, `SSD_DASH` on digit1, `SSD_9` on digit0.
- Blink: with `state_ctrl` = `STAT_DIGIT2`, digit2's slot shows 8'hFF whenever `blink_cnt`[3]=1 and its glyph otherwise. The other digits are never blanked.
- Leading zeros: with LZB=1 and digits 0,0,7,0, digits 3 and 2 are blank, digit1 shows `SSD_7` and digit0 shows `SSD_0`. With digits 0,0,0,0, only digit0 shows `SSD_0`.
- Mid-frame reset: assert `rst` for 1 cycle while digit 2 is active. The next edge gives 1111/FF, then scanning restarts with digit 0 for exactly 4 cycles.
- Invariant, checked by assertion over 1000 random cycles with random digits and `state_ctrl`: exactly one `ssd_ctl` bit is low after reset, and `ssd_out`[0] (dp) is always 1.
